// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Brief    : E-stage multiply/divide unit. Runs mult/multu/div/divu behind a
//            fixed-latency busy window, owns HI/LO and serves mthi/mtlo/
//            mfhi/mflo for the E-stage result mux.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [3:0]  mdu_op,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_result
);

    localparam int c_CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MFHI  = 4'd7;
    localparam logic [3:0] c_OP_MFLO  = 4'd8;

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // State
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_wr;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    // Datapath wires
    logic               w_accept;
    logic               w_is_div;
    logic [c_CNT_W-1:0] w_load;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_sden;
    logic [31:0]        w_uden;
    logic [31:0]        w_sq_mag;
    logic [31:0]        w_sr_mag;
    logic [31:0]        w_sq;
    logic [31:0]        w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_res_wr;

    // An op may only take effect when nothing is in flight and no commit cancel
    assign w_accept = ~r_busy & ~req;
    assign start    = w_accept & (mdu_op >= c_OP_MULT) & (mdu_op <= c_OP_DIVU);
    assign w_is_div = (mdu_op == c_OP_DIV) | (mdu_op == c_OP_DIVU);
    assign w_load   = w_is_div ? c_DIV_LOAD : c_MULT_LOAD;

    // Full-width products; operands are extended to 64 bits before multiplying
    assign w_prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide on magnitudes, then re-apply signs: quotient truncates
    // toward zero, remainder follows the dividend. The most negative dividend
    // has magnitude 0x80000000, which is exactly representable unsigned, so
    // 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    assign w_a_mag  = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign w_b_mag  = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    // Divisor of zero is replaced by one so the divider never sees x/0; the
    // result is discarded anyway because w_res_wr is low.
    assign w_sden   = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_uden   = (rt_val == 32'd0) ? 32'd1 : rt_val;
    assign w_sq_mag = w_a_mag / w_sden;
    assign w_sr_mag = w_a_mag % w_sden;
    assign w_sq     = (rs_val[31] ^ rt_val[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
    assign w_sr     = rs_val[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;
    assign w_uq     = rs_val / w_uden;
    assign w_ur     = rs_val % w_uden;

    // Select the 64-bit result to park in the pending registers
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_wr = 1'b1;
        case (mdu_op)
            c_OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
            c_OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
            c_OP_DIV:   begin w_res_hi = w_sr; w_res_lo = w_sq; w_res_wr = (rt_val != 32'd0); end
            c_OP_DIVU:  begin w_res_hi = w_ur; w_res_lo = w_uq; w_res_wr = (rt_val != 32'd0); end
            default:    w_res_wr = 1'b0;
        endcase
    end

    // Busy window: load the latency counter on start, count down to the commit edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= c_CNT_ZERO;
            r_busy    <= 1'b0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (start) begin
            r_cnt     <= w_load;
            r_busy    <= 1'b1;
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
        end else if (r_cnt != c_CNT_ZERO) begin
            r_cnt <= r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    // HI/LO: commit pending result on the last busy edge, else serve mthi/mtlo
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_cnt == c_CNT_ONE) begin
            if (r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (w_accept && (mdu_op == c_OP_MTHI)) begin
            r_hi <= rs_val;
        end else if (w_accept && (mdu_op == c_OP_MTLO)) begin
            r_lo <= rs_val;
        end
    end

    // Move-from read: plain view of the architectural registers, no mt bypass
    always_comb begin
        mf_result = 32'd0;
        if (mdu_op == c_OP_MFHI) begin
            mf_result = r_hi;
        end else if (mdu_op == c_OP_MFLO) begin
            mf_result = r_lo;
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_unit
// Brief    : Self-checking bench for mdu_unit. Expected HI/LO pairs are pushed
//            to a scoreboard queue at issue and popped when busy falls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

    localparam logic [3:0] c_NONE  = 4'd0;
    localparam logic [3:0] c_MULT  = 4'd1;
    localparam logic [3:0] c_MULTU = 4'd2;
    localparam logic [3:0] c_DIV   = 4'd3;
    localparam logic [3:0] c_DIVU  = 4'd4;
    localparam logic [3:0] c_MTHI  = 4'd5;
    localparam logic [3:0] c_MTLO  = 4'd6;
    localparam logic [3:0] c_MFHI  = 4'd7;
    localparam logic [3:0] c_MFLO  = 4'd8;
    localparam int         c_MULT_N = 5;
    localparam int         c_DIV_N  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [3:0]  mdu_op;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_result;

    exp_t        sb_q[$];
    int          n_total;
    int          n_pass;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit #(
        .MULT_CYCLES (c_MULT_N),
        .DIV_CYCLES  (c_DIV_N)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .mdu_op    (mdu_op),
        .req       (req),
        .start     (start),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .mf_result (mf_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hazard unit never presents a start or mt op while busy
    always @(posedge clk) begin
        if (!reset && busy && (mdu_op >= c_MULT) && (mdu_op <= c_MTLO))
            $error("hazard contract violated: op %0d while busy", mdu_op);
    end

    // Independent reference for random operations
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input exp_t cur);
        exp_t        r;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      rm;
        r = cur;
        case (op)
            c_MULT: begin
                sa = longint'(int'(a));
                sb = longint'(int'(b));
                p  = 64'(sa * sb);
                r  = {p[63:32], p[31:0]};
            end
            c_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                r = {p[63:32], p[31:0]};
            end
            c_DIV: if (b != 32'd0) begin
                sa = longint'(int'(a));
                sb = longint'(int'(b));
                q  = sa / sb;
                rm = sa % sb;
                p  = 64'(q);
                r.lo = p[31:0];
                p  = 64'(rm);
                r.hi = p[31:0];
            end
            c_DIVU: if (b != 32'd0) begin
                r.lo = a / b;
                r.hi = a % b;
            end
            default: r = cur;
        endcase
        return r;
    endfunction

    // Drive an op at the current negedge, check start, and take the edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_start);
        mdu_op = op;
        rs_val = a;
        rt_val = b;
        #1;
        n_total++;
        if (start !== exp_start)
            $display("FAIL issue_start op=%0d: got %b want %b", op, start, exp_start);
        else
            n_pass++;
        @(posedge clk);
    endtask

    // Count busy cycles after an issue edge, then pop and compare HI/LO
    task automatic wait_done(input string name, input int n_exp);
        int   cyc;
        bit   done;
        exp_t e;
        cyc  = 0;
        done = 0;
        @(negedge clk);
        mdu_op = c_NONE;
        req    = 1'b0;
        #1;
        while (!done && cyc <= 60) begin
            if (busy === 1'b1) begin
                cyc++;
                @(negedge clk);
                #1;
            end else begin
                done = 1;
            end
        end
        n_total++;
        if (!done || cyc != n_exp)
            $display("FAIL %s busy_len: got %0d want %0d (done=%0d)", name, cyc, n_exp, done);
        else
            n_pass++;
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s scoreboard empty: got hi=%h lo=%h want queued entry", name, hi, lo);
        end else begin
            e = sb_q.pop_front();
            if (hi !== e.hi || lo !== e.lo)
                $display("FAIL %s hilo: got %h_%h want %h_%h", name, hi, lo, e.hi, e.lo);
            else
                n_pass++;
            m_hi = e.hi;
            m_lo = e.lo;
        end
        @(negedge clk);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        sb_q.push_back('{hi: eh, lo: el});
        issue(op, a, b, 1'b1);
        wait_done(name, (op >= c_DIV) ? c_DIV_N : c_MULT_N);
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
        mdu_op = op;
        rs_val = a;
        @(posedge clk);
        @(negedge clk);
        mdu_op = c_NONE;
        if (op == c_MTHI) m_hi = a; else m_lo = a;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        req    = 1'b0;
        mdu_op = c_NONE;
        rs_val = 32'd0;
        rt_val = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || start !== 1'b0 || mf_result !== 32'd0)
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h start=%b mf=%h want 0s",
                     busy, hi, lo, start, mf_result);
        else
            n_pass++;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_reset_mid_div();
        do_mt(c_MTHI, 32'h0000_AAAA);
        do_mt(c_MTLO, 32'h0000_BBBB);
        issue(c_DIV, 32'd100, 32'd3, 1'b1);
        @(negedge clk);
        mdu_op = c_NONE;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1)
            $display("FAIL rst_mid_busy_before: got %b want 1", busy);
        else
            n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL rst_mid_clear: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        else
            n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL rst_mid_no_late_write: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        else
            n_pass++;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_mult();
        run_op("mult",  c_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", c_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        run_op("div_neg", c_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",    c_DIVU, 32'd7,         32'd2, 32'd1,         32'd3);
    endtask

    task automatic test_div_edge();
        run_op("div_ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        do_mt(c_MTHI, 32'h11);
        do_mt(c_MTLO, 32'h22);
        n_total++;
        if (hi !== 32'h11 || lo !== 32'h22)
            $display("FAIL mt_setup: got hi=%h lo=%h want 11/22", hi, lo);
        else
            n_pass++;
        run_op("divu_by0", c_DIVU, 32'd5, 32'd0, 32'h11, 32'h22);
    endtask

    task automatic test_mt_mf();
        mdu_op = c_MTHI;
        rs_val = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        mdu_op = c_MFHI;
        #1;
        n_total++;
        if (mf_result !== 32'h1234)
            $display("FAIL mfhi_after_mthi: got %h want 00001234", mf_result);
        else
            n_pass++;
        m_hi = 32'h1234;
        mdu_op = c_MFLO;
        #1;
        n_total++;
        if (mf_result !== m_lo)
            $display("FAIL mflo_read: got %h want %h", mf_result, m_lo);
        else
            n_pass++;
        @(negedge clk);
        mdu_op = c_NONE;
    endtask

    task automatic test_req_cancel();
        req = 1'b1;
        issue(c_MULT, 32'd9, 32'd9, 1'b0);
        @(negedge clk);
        mdu_op = c_MTLO;
        rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        mdu_op = c_NONE;
        req    = 1'b0;
        n_total++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo)
            $display("FAIL req_cancel: got busy=%b hi=%h lo=%h want 0/%h/%h", busy, hi, lo, m_hi, m_lo);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   bad;
        bad = 0;
        sb_q.push_back('{hi: 32'h0000_0000, lo: 32'h0000_0F00});
        issue(c_MULT, 32'h30, 32'h50, 1'b1);
        for (int k = 1; k <= c_MULT_N; k++) begin
            @(negedge clk);
            mdu_op = c_MFLO;
            #1;
            if ((start | busy) !== 1'b1 || start !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0)
            $display("FAIL b2b_stall_window: got %0d bad cycles want 0", bad);
        else
            n_pass++;
        @(negedge clk);
        #1;
        e = sb_q.pop_front();
        n_total++;
        if (busy !== 1'b0 || mf_result !== e.lo || hi !== e.hi)
            $display("FAIL b2b_commit: got busy=%b mf=%h hi=%h want 0/%h/%h", busy, mf_result, hi, e.lo, e.hi);
        else
            n_pass++;
        m_hi = e.hi;
        m_lo = e.lo;
        sb_q.push_back('{hi: 32'd2, lo: 32'd14});
        issue(c_DIV, 32'd100, 32'd7, 1'b1);
        wait_done("b2b_div", c_DIV_N);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) a = {a[31], 31'($urandom_range(0, 1000))};
            e = model(op, a, b, '{hi: m_hi, lo: m_lo});
            sb_q.push_back(e);
            issue(op, a, b, 1'b1);
            wait_done("random", (op >= c_DIV) ? c_DIV_N : c_MULT_N);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_reset_mid_div();
        test_mult();
        test_div();
        test_div_edge();
        test_mt_mf();
        test_req_cancel();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
